// File: rtl/wb_regfile.sv
// Write-back register file: 32 x DATA_W GPRs plus HI/LO, two combinational read ports with write-through.
// Optional macro WB_HILO_BYPASS_EN forwards an in-flight HI/LO write straight to hi_o/lo_o.
module wb_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_wreg,
  input  logic [ADDR_W-1:0] wb_wd,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              wb_whilo,
  input  logic [DATA_W-1:0] wb_hi,
  input  logic [DATA_W-1:0] wb_lo,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  if (NUM_REGS != (1 << ADDR_W)) begin : g_bad_cfg
    $error("wb_regfile: NUM_REGS must equal 2**ADDR_W");
  end

  logic [DATA_W-1:0] gpr_q [NUM_REGS];
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              gpr_we;

  // Address 0 is hardwired to zero, so its write enable is simply never raised.
  assign gpr_we = wb_wreg && (wb_wd != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        gpr_q[i] <= '0;
      end
    end else if (gpr_we) begin
      gpr_q[wb_wd] <= wb_wdata;
    end
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (wb_whilo) begin
      hi_d = wb_hi;
      lo_d = wb_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // Read ports: reset, disable and r0 force zero; a matching in-flight write is forwarded.
  always_comb begin
    rdata1 = '0;
    if (!rst && re1 && (raddr1 != '0)) begin
      if (wb_wreg && (wb_wd == raddr1)) begin
        rdata1 = wb_wdata;
      end else begin
        rdata1 = gpr_q[raddr1];
      end
    end
  end

  always_comb begin
    rdata2 = '0;
    if (!rst && re2 && (raddr2 != '0)) begin
      if (wb_wreg && (wb_wd == raddr2)) begin
        rdata2 = wb_wdata;
      end else begin
        rdata2 = gpr_q[raddr2];
      end
    end
  end

  always_comb begin
    hi_o = '0;
    lo_o = '0;
    if (!rst) begin
`ifdef WB_HILO_BYPASS_EN
      hi_o = hi_d;
      lo_o = lo_d;
`else
      hi_o = hi_q;
      lo_o = lo_q;
`endif
    end
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the MEM/WB pipeline register: consumes the registered write-back bundle (GPR write, HI/LO write) and commits it to architectural state.
- 32 x 32-bit general-purpose register file plus HI/LO special registers.
- Two combinational read ports for ID, with same-cycle write-through bypass.
- HI/LO read outputs for EX.

Parameters:
- DATA_W, 32, width of every register and data port
- ADDR_W, 5, GPR address width
- NUM_REGS, 32, GPR count; must equal 2**ADDR_W

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- wb_wreg  input  1  GPR write enable from MEM/WB
- wb_wd  input  ADDR_W  GPR write address
- wb_wdata  input  DATA_W  GPR write data
- wb_whilo  input  1  HI/LO write enable
- wb_hi  input  DATA_W  HI write data
- wb_lo  input  DATA_W  LO write data
- re1  input  1  read port 1 enable
- raddr1  input  ADDR_W  read port 1 address
- rdata1  output  DATA_W  read port 1 data (combinational)
- re2  input  1  read port 2 enable
- raddr2  input  ADDR_W  read port 2 address
- rdata2  output  DATA_W  read port 2 data (combinational)
- hi_o  output  DATA_W  current HI
- lo_o  output  DATA_W  current LO

Behaviour:
- Clocking: one clock, clk. rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset:
  - On a clk edge with rst=1, all GPRs, HI and LO clear to 0.
  - Any write presented in that cycle is dropped (reset wins).
  - While rst=1, rdata1, rdata2, hi_o and lo_o drive 0 regardless of other inputs.
- GPR write:
  - On a clk edge with rst=0, wb_wreg=1 and wb_wd!=0: reg[wb_wd] <= wb_wdata.
  - Writes to address 0 are discarded; reg[0] is always 0.
- HI/LO write:
  - On a clk edge with rst=0 and wb_whilo=1: HI <= wb_hi and LO <= wb_lo, both in the same cycle.
  - HI/LO writes are independent of wb_wreg; both may occur in one cycle.
- Read port n (n=1,2), combinational, evaluated in this priority order:
  1. rst=1 -> 0
  2. re_n=0 -> 0
  3. raddr_n=0 -> 0
  4. wb_wreg=1 and wb_wd==raddr_n -> wb_wdata (write-through bypass; the read sees the value being committed this cycle)
  5. otherwise -> reg[raddr_n]
- The two read ports are fully independent and may name the same address.
- HI/LO outputs:
  - hi_o/lo_o reflect the registered HI/LO.
  - The new value is visible the cycle after a write unless WB_HILO_BYPASS_EN is defined.
- Latency:
  - Write commits at the edge it is presented.
  - Registered read path sees it one cycle later; bypass path sees it in the same cycle.
- No stall input. MEM/WB delivers a NOP bundle (wb_wreg=0, wb_whilo=0) on bubbles, and the block treats it as idle.
- No X propagation: unused address bits never index out of range (NUM_REGS = 2**ADDR_W).

Optional Feature:
- Macro: WB_HILO_BYPASS_EN.
- Defined:
  - hi_o = wb_whilo ? wb_hi : HI
  - lo_o = wb_whilo ? wb_lo : LO
  - Both still forced to 0 while rst=1.
- Undefined: hi_o/lo_o are purely the registered HI/LO; a write becomes visible one cycle later.

Test Plan:
- Reset: assert rst=1 with wb_wreg=1, wb_wd=5, wb_wdata=32'hDEADBEEF for one edge, then rst=0, re1=1, raddr1=5 -> rdata1=0; hi_o=lo_o=0.
- Write then read: write reg[3]=32'h12345678, next cycle wb_wreg=0, re1=1, raddr1=3 -> rdata1=32'h12345678. With re1=0 -> rdata1=0.
- Bypass: same cycle wb_wreg=1, wb_wd=7, wb_wdata=32'hA5A5A5A5, re1=re2=1, raddr1=raddr2=7 -> rdata1=rdata2=32'hA5A5A5A5 before the edge; reg[7] holds it after.
- Zero register: wb_wreg=1, wb_wd=0, wb_wdata=32'hFFFFFFFF, re1=1, raddr1=0 -> rdata1=0 in that cycle and after the edge.
- HI/LO: wb_whilo=1, wb_hi=32'h1, wb_lo=32'h2 for one edge.
  - In-cycle: with WB_HILO_BYPASS_EN, hi_o/lo_o = 1/2 in the same cycle; without it, old values (0/0).
  - After the edge: hi_o/lo_o = 1/2 in both builds.
- Reset mid-operation: preload reg[9]=32'h55, HI=32'h66; assert rst=1 with wb_whilo=1 for one edge -> reg[9]=0, HI=0, LO=0; the write is not committed.
